// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared op/state encodings and default width for the iterative multiply/divide engine
package multdiv_pkg;
  localparam int DEF_DATA_W = 32;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_e;
endpackage

// File: rtl/multdiv_sequencer_twos_abs.sv
// twos_abs: magnitude and sign of a two's-complement value; the most negative input maps to its unsigned magnitude
module twos_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag,
  output logic         neg
);
  assign neg = x[W-1];
  assign mag = neg ? -x : x;
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative signed shift-add multiply / restoring divide producing HI/LO with write strobes
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              hi_we,
  output logic              lo_we
);
  state_e state, state_nxt;
  logic op_q, sa_q, sb_q, dz_q;
  logic [DATA_W-1:0] abs_a, abs_b, mag_a, mag_b;
  logic neg_a, neg_b, last, accept, zero_div;
  logic [CNT_W-1:0] cnt;
  logic [2*DATA_W-1:0] acc, acc_nxt, prod;
  logic [DATA_W:0] sum, diff;
  logic [DATA_W-1:0] quo, rem;
  twos_abs #(.W(DATA_W)) u_abs_a (.x(a), .mag(mag_a), .neg(neg_a));
  twos_abs #(.W(DATA_W)) u_abs_b (.x(b), .mag(mag_b), .neg(neg_b));
  assign accept   = state == IDLE && start;
  assign zero_div = op == OP_DIV && b == '0;
  assign last     = cnt == CNT_W'(DATA_W - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start ? (zero_div ? FINISH : RUN) : IDLE)
              : (state == RUN) ? (last ? FINISH : RUN) : IDLE;
  end
  // One iteration: mult adds |a| into the upper half then shifts right; div shifts left and trial-subtracts |b|
  always_comb begin
    sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, abs_a} : '0);
    diff    = acc[2*DATA_W-1:DATA_W-1] - {1'b0, abs_b};
    acc_nxt = (op_q == OP_DIV)
              ? (diff[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0} : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1})
              : {sum, acc[DATA_W-1:1]};
    prod    = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
    quo     = (sa_q ^ sb_q) ? -acc_nxt[DATA_W-1:0] : acc_nxt[DATA_W-1:0];
    rem     = sa_q ? -acc_nxt[2*DATA_W-1:DATA_W] : acc_nxt[2*DATA_W-1:DATA_W];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dz_q   <= 1'b0;
      abs_a  <= '0;
      abs_b  <= '0;
      cnt    <= '0;
      acc    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (accept) begin
      op_q  <= op;
      sa_q  <= neg_a;
      sb_q  <= neg_b;
      dz_q  <= zero_div;
      abs_a <= mag_a;
      abs_b <= mag_b;
      cnt   <= '0;
      acc   <= (op == OP_DIV) ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        hi_out <= (op_q == OP_DIV) ? rem : prod[2*DATA_W-1:DATA_W];
        lo_out <= (op_q == OP_DIV) ? quo : prod[DATA_W-1:0];
      end
    end
  end
  assign busy        = state != IDLE;
  assign done        = state == FINISH;
  assign div_by_zero = done && dz_q;
  assign hi_we       = done && !dz_q;
  assign lo_we       = done && !dz_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed vectors with a result scoreboard checked by a done-triggered monitor
module tb_multdiv_sequencer;
  import multdiv_pkg::*;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_by_zero, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;
  logic [31:0] last_hi = '0, last_lo = '0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t sb[$];
  multdiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out), .hi_we(hi_we), .lo_we(lo_we)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_width", done, 0);
      prev_done = done;
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got hi=%0h lo=%0h with no pending request", hi_out, lo_out);
        end else begin
          e = sb.pop_front();
          chk("hi_out", hi_out, e.hi);
          chk("lo_out", lo_out, e.lo);
          chk("div_by_zero", div_by_zero, e.dz);
          chk("hi_we", hi_we, !e.dz);
          chk("lo_we", lo_we, !e.dz);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", busy, 1);
        end
      end
    end
  end
  task automatic issue(logic o, logic [31:0] x, logic [31:0] y, logic [31:0] eh, logic [31:0] el, logic dz);
    exp_t e;
    @(negedge clk);
    e.hi  = dz ? last_hi : eh;
    e.lo  = dz ? last_lo : el;
    e.dz  = dz;
    e.cyc = cyc + (dz ? 1 : 33);
    sb.push_back(e);
    if (!dz) begin
      last_hi = eh;
      last_lo = el;
    end
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    op = ~o;
    a = $urandom;
    b = $urandom;
  endtask
  task automatic run(int eb);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, eb);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", {hi_we, lo_we, div_by_zero}, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run(33);
    issue(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run(33);
    issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run(33);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(33);
    issue(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run(33);
    issue(OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 1'b0);
    run(33);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run(33);
    issue(OP_DIV, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
    run(1);
    // A second start mid-run must be dropped; a zero divisor makes any acceptance show up fast
    issue(OP_MULT, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    op = OP_DIV;
    a = 32'd5;
    b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    run(24);
    repeat (2) @(negedge clk);
    issue(OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", {done, hi_we, lo_we, div_by_zero}, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    issue(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    run(33);
    repeat (3) @(negedge clk);
    chk("pending_results", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no completion, required end of stimulus");
    $fatal(1);
  end
endmodule
